// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size / legality decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_FIN   = 2'd3
  } lsu_state_t;

  // Access size in bytes (1, 2 or 4); the sign bit of funct3 does not matter.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte strobes for the current beat, store data
// rotated onto its lanes, and per-result-byte select into the two-beat buffer.
module lsu_lane_align (
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        beat,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rot,
  output logic [11:0] load_sel
);

  // A lane is enabled when its byte position within the access (beat*4 + lane - off)
  // falls inside [0, size); negative positions wrap to large 4-bit values.
  always_comb begin
    wstrb    = '0;
    load_sel = '0;
    for (int l = 0; l < 4; l++) begin
      wstrb[l] = (4'(l) + (beat ? 4'd4 : 4'd0) - {2'b00, off}) < {1'b0, size};
      load_sel[l*3 +: 3] = {1'b0, off} + 3'(l);
    end
  end

  always_comb begin
    case (off)
      2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
      2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
      2'd3:    wdata_rot = {wdata[7:0],  wdata[31:8]};
      default: wdata_rot = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request per handshake, word-boundary splitting
// into two beats, and a single registered response per request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-3:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [1:0]       state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the response is a single-cycle pulse with
  // no backpressure.
  lsu_state_t       state, state_nxt;
  logic [WIDTH-1:0] addr_q, wdata_q, low_q, load_val;
  logic             store_q, err_q;
  logic [2:0]       f3_q, size;
  logic [1:0]       off;
  logic             split, beat1, fire;
  logic [3:0]       lane_strb;
  logic [WIDTH-1:0] lane_wdata;
  logic [11:0]      load_sel;
  logic [63:0]      beat_bytes;
  logic [7:0]       b0, b1, b2, b3;

  assign off   = addr_q[1:0];
  assign size  = access_size(f3_q);
  assign split = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign beat1 = (state == ST_BEAT1);
  assign fire  = req_valid && req_ready;

  lsu_lane_align u_align (
    .off       (off),
    .size      (size),
    .beat      (beat1),
    .wdata     (wdata_q),
    .wstrb     (lane_strb),
    .wdata_rot (lane_wdata),
    .load_sel  (load_sel)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = funct3_legal(req_store, req_funct3) ? ST_BEAT0 : ST_FIN;
      ST_BEAT0: state_nxt = split ? ST_BEAT1 : ST_FIN;
      ST_BEAT1: state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Memory outputs decode from registered state only, so reset drops them at once.
  assign req_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_BEAT0) || beat1;
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? addr_q[WIDTH-1:2] + {{(WIDTH-3){1'b0}}, beat1} : '0;
  assign mem_wstrb = mem_req ? lane_strb : 4'b0000;
  assign mem_wdata = mem_req ? lane_wdata : '0;
  assign state_dbg = state;

  // In FIN the bytes of a split access span {last beat, first beat}.
  always_comb begin
    beat_bytes = split ? {mem_rdata, low_q} : {32'b0, mem_rdata};
    b0 = beat_bytes[{load_sel[2:0],  3'b000} +: 8];
    b1 = beat_bytes[{load_sel[5:3],  3'b000} +: 8];
    b2 = beat_bytes[{load_sel[8:6],  3'b000} +: 8];
    b3 = beat_bytes[{load_sel[11:9], 3'b000} +: 8];
    case (f3_q)
      F3_B:    load_val = {{24{b0[7]}}, b0};
      F3_H:    load_val = {{16{b1[7]}}, b1, b0};
      F3_BU:   load_val = {24'b0, b0};
      F3_HU:   load_val = {16'b0, b1, b0};
      default: load_val = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      f3_q       <= 3'b000;
      err_q      <= 1'b0;
      low_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        store_q <= req_store;
        f3_q    <= req_funct3;
        err_q   <= !funct3_legal(req_store, req_funct3);
      end
      if (beat1) low_q <= mem_rdata;
      resp_valid <= (state == ST_FIN);
      resp_err   <= (state == ST_FIN) && err_q;
      resp_data  <= ((state == ST_FIN) && !err_q && !store_q) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, word RAM model
// driven by the DUT's beats, directed and randomized requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram  [512];
  logic [7:0]  gold [2048];

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .state_dbg  (state_dbg)
  );

  // Addresses used stay in 0..0x3FF and 0xFFFFFC00..0xFFFFFFFF.
  function automatic logic [8:0] ridx(input logic [29:0] w);
    return {w[29], w[7:0]};
  endfunction

  function automatic logic [10:0] gidx(input logic [31:0] a);
    return {a[31], a[9:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_req === 1'b1) begin
      mem_rdata <= ram[ridx(mem_addr)];
      if (mem_we === 1'b1)
        for (int l = 0; l < 4; l++)
          if (mem_wstrb[l]) ram[ridx(mem_addr)][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end
  end

  task automatic preload(input logic [29:0] w, input logic [31:0] v);
    ram[ridx(w)] <= v;
    for (int l = 0; l < 4; l++) gold[gidx({w, 2'(l)})] = v[l*8 +: 8];
  endtask

  // Issue one request at a negedge in IDLE and check everything about it;
  // returns at the negedge of the response cycle.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    logic        legal;
    int          size, cyc, exp_lat, bi;
    logic [31:0] last_a, ba, exp_data, mask, exp_word;
    logic [29:0] w0, w1;
    logic [3:0]  exp_strb [2];
    logic [31:0] exp_wd [2];
    logic [29:0] exp_q [$];
    logic [29:0] got_addr [$];
    logic [3:0]  got_strb [$];
    logic [31:0] got_wd [$];
    logic        got_we [$];
    int          got_cyc [$];

    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    w0 = a[31:2];
    last_a = a + 32'(size - 1);
    w1 = last_a[31:2];
    exp_strb[0] = '0; exp_strb[1] = '0;
    exp_wd[0] = '0;   exp_wd[1] = '0;
    exp_data = '0;
    if (legal) begin
      exp_q.push_back(w0);
      if (w1 != w0) exp_q.push_back(w1);
      for (int k = 0; k < size; k++) begin
        ba = a + 32'(k);
        bi = (ba[31:2] == w0) ? 0 : 1;
        exp_strb[bi][ba[1:0]] = 1'b1;
        exp_wd[bi][{ba[1:0], 3'b000} +: 8] = wd[k*8 +: 8];
        if (!st) exp_data[k*8 +: 8] = gold[gidx(ba)];
      end
      if (!st && f3 == 3'd0 && exp_data[7])  exp_data[31:8]  = '1;
      if (!st && f3 == 3'd1 && exp_data[15]) exp_data[31:16] = '1;
    end
    exp_lat = legal ? exp_q.size() + 2 : 2;

    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_before addr=%h: got %b expected 1", a, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 12) begin
      if (mem_req === 1'b1) begin
        got_addr.push_back(mem_addr); got_we.push_back(mem_we);
        got_strb.push_back(mem_wstrb); got_wd.push_back(mem_wdata); got_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    got = resp_data;

    n_vec++;
    if (cyc != exp_lat) begin
      n_err++; $display("FAIL latency st=%b f3=%0d addr=%h: got %0d expected %0d", st, f3, a, cyc, exp_lat);
    end
    n_vec++;
    if (resp_err !== !legal) begin
      n_err++; $display("FAIL resp_err f3=%0d addr=%h: got %b expected %b", f3, a, resp_err, !legal);
    end
    n_vec++;
    if (resp_data !== exp_data) begin
      n_err++; $display("FAIL resp_data st=%b f3=%0d addr=%h: got %h expected %h", st, f3, a, resp_data, exp_data);
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_in_resp addr=%h: got %b expected 1", a, req_ready);
    end
    n_vec++;
    if (got_addr.size() != exp_q.size()) begin
      n_err++; $display("FAIL beat_count addr=%h: got %0d expected %0d", a, got_addr.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_addr.size(); i++) begin
      n_vec++;
      if (got_addr[i] !== exp_q[i] || got_cyc[i] != i + 1 || got_we[i] !== st) begin
        n_err++;
        $display("FAIL beat%0d addr=%h: got wa=%h cyc=%0d we=%b expected wa=%h cyc=%0d we=%b",
                 i, a, got_addr[i], got_cyc[i], got_we[i], exp_q[i], i + 1, st);
      end
      if (st) begin
        for (int l = 0; l < 4; l++) mask[l*8 +: 8] = {8{exp_strb[i][l]}};
        n_vec++;
        if (got_strb[i] !== exp_strb[i] || (got_wd[i] & mask) !== exp_wd[i]) begin
          n_err++;
          $display("FAIL store_lanes%0d addr=%h: got strb=%b data=%h expected strb=%b data=%h",
                   i, a, got_strb[i], got_wd[i] & mask, exp_strb[i], exp_wd[i]);
        end
      end
    end

    if (legal && st) begin
      for (int k = 0; k < size; k++) gold[gidx(a + 32'(k))] = wd[k*8 +: 8];
      foreach (exp_q[i]) begin
        for (int l = 0; l < 4; l++) exp_word[l*8 +: 8] = gold[gidx({exp_q[i], 2'(l)})];
        n_vec++;
        if (ram[ridx(exp_q[i])] !== exp_word) begin
          n_err++;
          $display("FAIL mem_word wa=%h: got %h expected %h", exp_q[i], ram[ridx(exp_q[i])], exp_word);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, mem_req, mem_we, mem_wstrb} !== 7'b1000000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 1000000", {req_ready, mem_req, mem_we, mem_wstrb});
    end
    n_vec++;
    if (mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_mem: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata);
    end
    n_vec++;
    if ({resp_valid, resp_err, resp_data} !== 34'd0) begin
      n_err++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected 0", resp_valid, resp_err, resp_data);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL after_reset: got ready=%b valid=%b expected 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] got;
    preload(30'h40, 32'h8899AABB);
    preload(30'h80, 32'h80112233);
    preload(30'h41, 32'h44332211);
    preload(30'h42, 32'h88776655);
    @(negedge clk);
    do_req(1'b0, 3'b010, 32'h100, '0, got);
    n_vec++;
    if (got !== 32'h8899AABB) begin n_err++; $display("FAIL tp_lw: got %h expected 8899aabb", got); end
    do_req(1'b0, 3'b000, 32'h203, '0, got);
    n_vec++;
    if (got !== 32'hFFFFFF80) begin n_err++; $display("FAIL tp_lb: got %h expected ffffff80", got); end
    do_req(1'b0, 3'b100, 32'h203, '0, got);
    n_vec++;
    if (got !== 32'h00000080) begin n_err++; $display("FAIL tp_lbu: got %h expected 00000080", got); end
    do_req(1'b0, 3'b001, 32'h202, '0, got);
    n_vec++;
    if (got !== 32'hFFFF8011) begin n_err++; $display("FAIL tp_lh: got %h expected ffff8011", got); end
    do_req(1'b0, 3'b010, 32'h105, '0, got);
    n_vec++;
    if (got !== 32'h55443322) begin n_err++; $display("FAIL tp_split_lw: got %h expected 55443322", got); end
    do_req(1'b1, 3'b010, 32'h7, 32'hDDCCBBAA, got);
    n_vec++;
    if (ram[ridx(30'h1)][31:24] !== 8'hAA || ram[ridx(30'h2)][23:0] !== 24'hDDCCBB) begin
      n_err++; $display("FAIL tp_split_sw: got w1=%h w2=%h expected AA in lane3, DDCCBB in lanes0..2",
                        ram[ridx(30'h1)], ram[ridx(30'h2)]);
    end
    do_req(1'b0, 3'b001, 32'hFFFFFFFF, '0, got);
    do_req(1'b0, 3'b011, 32'h100, '0, got);
    do_req(1'b1, 3'b100, 32'h104, 32'h12345678, got);
    do_req(1'b1, 3'b001, 32'h13, 32'h0000BEEF, got);
    do_req(1'b0, 3'b101, 32'h13, '0, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    do_req(1'b1, 3'b000, 32'h31, 32'h000000C5, got);
    do_req(1'b0, 3'b000, 32'h31, '0, got);
    do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, got);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, '0, got);
    do_req(1'b0, 3'b110, 32'h0, '0, got);
    do_req(1'b0, 3'b100, 32'hFFFFFFFF, '0, got);
  endtask

  task automatic test_random();
    logic [31:0] got, a;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 2) == 0) a = 32'hFFFFFC00 | 32'($urandom_range(0, 1023));
      else a = 32'($urandom_range(0, 1023));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic        seen;
    preload(30'h41, 32'h44332211);
    preload(30'h42, 32'h88776655);
    @(negedge clk);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h105; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h42) begin
      n_err++; $display("FAIL mid_beat1: got req=%b addr=%h expected 1 42", mem_req, mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_drop: got req=%b ready=%b expected 0 1", mem_req, req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got resp_valid pulse expected none"); end
    do_req(1'b0, 3'b010, 32'h100, '0, got);
    n_vec++;
    if (got !== 32'h8899AABB) begin n_err++; $display("FAIL post_reset_lw: got %h expected 8899aabb", got); end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      ram[i] <= v;
      for (int l = 0; l < 4; l++) gold[i*4 + l] = v[l*8 +: 8];
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store initiator between the single-cycle core's execute/memory stage and a word-organised data RAM with byte-write strobes. Accepts one load or store per handshake, selected by RISC-V funct3 (lb/lh/lw/lbu/lhu/sb/sh/sw). Splits misaligned accesses that cross a word boundary into two word beats. Returns a sign- or zero-extended load result, or store completion, one registered response per request.

## Interface
- WIDTH, 32, data/address width; only 32 legal
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  access type (RISC-V load/store funct3)
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data (low bytes used)
- mem_req  output  1  memory beat active this cycle
- mem_we  output  1  beat is a write
- mem_addr  output  WIDTH-2  word address
- mem_wstrb  output  4  byte-lane write enables
- mem_wdata  output  WIDTH  lane-aligned write data
- mem_rdata  input  WIDTH  read word; valid the cycle after a read beat
- resp_valid  output  1  one-cycle response pulse
- resp_data  output  WIDTH  load result (0 for stores/errors)
- resp_err  output  1  illegal funct3

## Operation
- States: IDLE, BEAT0, BEAT1, FIN. Handshake fires when req_valid && req_ready; request fields latched then.
- Legal funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu; stores legal only for 000/001/010. Anything else: no memory beat, IDLE->FIN, resp_err=1, resp_data=0.
- size = 1/2/4 bytes; off = addr[1:0]. Split when off+size > 4 (lh off 3; lw off 1,2,3).
- BEAT0: mem_addr = addr[31:2]; lanes off..min(3, off+size-1). Next: BEAT1 if split, else FIN.
- BEAT1: mem_addr = addr[31:2]+1, modulo 2^30 (wraps 0x3FFFFFFF->0). Lanes 0..off+size-5. mem_rdata (beat-0 data) captured into low buffer. Next FIN.
- FIN: no beat; mem_rdata is last beat's data. Bytes assembled in address order, then extended: sign from the top byte accessed for b/h, zero for bu/hu. Loads result into resp_data; stores resp_data=0. resp_valid set; next IDLE.
- Store data: req_wdata byte k goes to lane (off+k) mod 4. Unused lanes are strobe 0, data don't-care.
- mem_we = req_store in both beats; mem_wstrb = 0 when mem_req=0.
- Stores and loads use identical state sequence/latency.

## Timing
- Handshake at edge ending cycle T.
- Aligned: BEAT0 at T+1, FIN T+2, resp_valid T+3.
- Split: BEAT0 T+1, BEAT1 T+2, FIN T+3, resp_valid T+4.
- Illegal: FIN T+1, resp_valid T+2.
- req_ready high in the resp_valid cycle (state IDLE), so back-to-back requests are possible. resp_valid is exactly one cycle; no backpressure on response.
- Memory fixed 1-cycle read latency, never stalls.
- Reset: state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_err=0. Mid-operation reset aborts silently: mem_req drops asynchronously, no response issued, and a half-split store may leave one beat written.
- All outputs registered or decoded from registered state only; no combinational req->mem path.

## Structure
- Shared package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, size decode function.
- One sub-module lsu_lane_align: combinational; given off, size, beat index, produces wstrb, rotated wdata and byte-select for load assembly. The top module holds FSM, latches and response registers.

## Test plan
- Aligned lw addr 0x100, mem word 0x8899AABB -> beat mem_addr 0x40 at T+1; resp_data 0x8899AABB at T+3, resp_err=0.
- lb addr 0x203, word 0x80112233 -> resp_data 0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x202 -> 0xFFFF8011.
- Split lw addr 0x0000_0105, words[0x41]=0x44332211, [0x42]=0x88776655 -> beats 0x41 then 0x42; resp_data 0x55443322 at T+4.
- Split sw addr 0x7, wdata 0xDDCCBBAA -> beat0 addr 1 strb 1000 lane3=AA; beat1 addr 2 strb 0111 lanes0..2=BB,CC,DD.
- Wrap: lh addr 0xFFFFFFFF -> beats 0x3FFFFFFF then 0x00000000. Illegal funct3 011 -> no mem_req, resp_err=1 at T+2.
- Reset asserted during BEAT1 of a split load -> mem_req low immediately, no resp_valid. Following aligned load completes normally at T+3.
